// File: rtl/vector_csr_file_pkg.sv
// Shared types and constants for the vector CSR file.
// Provides: CSR address map, csr_op_e access opcodes, vtype_t storage layout,
// cfg_state_e configuration FSM states and the vtype reset value.
package vector_csr_pkg;

  localparam logic [11:0] CSR_VSTART = 12'h008;
  localparam logic [11:0] CSR_VXSAT  = 12'h009;
  localparam logic [11:0] CSR_VXRM   = 12'h00A;
  localparam logic [11:0] CSR_VCSR   = 12'h00F;
  localparam logic [11:0] CSR_VL     = 12'hC20;
  localparam logic [11:0] CSR_VTYPE  = 12'hC21;
  localparam logic [11:0] CSR_VLENB  = 12'hC22;

  localparam int unsigned VTYPE_W = 32;

  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_e;

  typedef struct packed {
    logic                 vill;
    logic [VTYPE_W-10:0]  reserved;
    logic                 vma;
    logic                 vta;
    logic [2:0]           vsew;
    logic [2:0]           vlmul;
  } vtype_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2
  } cfg_state_e;

  localparam vtype_t VTYPE_RESET = '{vill: 1'b1, default: '0};

endpackage

// File: rtl/vector_csr_file_if.sv
// Bus interface of the vector CSR file: vsetvl configuration handshake and
// Zicsr-style CSR access/response channel.
// master: decode/issue side (drives requests); slave: the CSR file.
interface vector_csr_file_if #(
  parameter int unsigned XLEN = 32
);
  logic            cfg_valid;
  logic            cfg_ready;
  logic [XLEN-1:0] cfg_avl;
  logic [XLEN-1:0] cfg_vtype;
  logic            cfg_keep_vl;
  logic            cfg_set_max;
  logic            cfg_rsp_valid;
  logic [XLEN-1:0] cfg_rsp_vl;

  logic            csr_valid;
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_rsp_valid;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  modport master (
    output cfg_valid, cfg_avl, cfg_vtype, cfg_keep_vl, cfg_set_max,
    input  cfg_ready, cfg_rsp_valid, cfg_rsp_vl,
    output csr_valid, csr_addr, csr_op, csr_wdata,
    input  csr_rsp_valid, csr_rdata, csr_illegal
  );

  modport slave (
    input  cfg_valid, cfg_avl, cfg_vtype, cfg_keep_vl, cfg_set_max,
    output cfg_ready, cfg_rsp_valid, cfg_rsp_vl,
    input  csr_valid, csr_addr, csr_op, csr_wdata,
    output csr_rsp_valid, csr_rdata, csr_illegal
  );
endinterface

// File: rtl/vector_csr_file_vlmax_calc.sv
// vlmax_calc: combinational VLMAX and vtype legality from a requested vtype.
// Ports: vtype_i (raw XLEN vtype), vlmax_o (0 when illegal), illegal_o.
// Macro VCSR_FRACTIONAL_LMUL_EN enables fractional LMUL (vlmul 5..7).
module vlmax_calc
  import vector_csr_pkg::*;
#(
  parameter int unsigned VLEN = 128,
  parameter int unsigned ELEN = 32,
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]              vtype_i,
  output logic [$clog2(VLEN+1)-1:0]    vlmax_o,
  output logic                         illegal_o
);
  localparam int unsigned VL_W = $clog2(VLEN+1);

  logic [2:0]  vsew;
  logic [2:0]  vlmul;
  int unsigned sew;
  int unsigned per_reg;
  int unsigned vlmax;
`ifdef VCSR_FRACTIONAL_LMUL_EN
  int unsigned frac_shift;
`endif

  always_comb begin
    vsew      = vtype_i[5:3];
    vlmul     = vtype_i[2:0];
    sew       = 32'd8 << vsew;
    per_reg   = VLEN / sew;
    vlmax     = 0;
    illegal_o = 1'b0;
`ifdef VCSR_FRACTIONAL_LMUL_EN
    frac_shift = 0;
`endif
    if (vsew > 3'd2)                illegal_o = 1'b1;
    if (sew > ELEN)                 illegal_o = 1'b1;
    if (vlmul == 3'd4)              illegal_o = 1'b1;
    // any bit above vma/vta is reserved
    if ((vtype_i >> 8) != '0)       illegal_o = 1'b1;
    if (!vlmul[2]) begin
      vlmax = per_reg << vlmul;
    end else if (vlmul != 3'd4) begin
`ifdef VCSR_FRACTIONAL_LMUL_EN
      // LMUL = 1/2^(8-vlmul); SEW must also fit in ELEN*LMUL
      frac_shift = 32'd8 - 32'(vlmul);
      vlmax      = per_reg >> frac_shift;
      if (sew > (ELEN >> frac_shift)) illegal_o = 1'b1;
`else
      illegal_o = 1'b1;
`endif
    end
    vlmax_o = illegal_o ? '0 : VL_W'(vlmax);
  end

endmodule

// File: rtl/vector_csr_file.sv
// vector_csr_file: vector CSR block (vstart, vxsat, vxrm, vcsr, vl, vtype, vlenb).
// Ports: clk, n_reset (async active-low); bus (slave modport: vsetvl cfg
// handshake with 2-cycle commit, CSR access/response); sat_flag,
// vstart_we/vstart_wdata/vstart_clr from execution; lane outputs vl, vsew,
// vlmul, vta, vma, vill, vstart, vxrm (all registered).
// Macro VCSR_FRACTIONAL_LMUL_EN (in vlmax_calc) enables fractional LMUL.
module vector_csr_file
  import vector_csr_pkg::*;
#(
  parameter int unsigned VLEN = 128,
  parameter int unsigned ELEN = 32,
  parameter int unsigned XLEN = 32
) (
  input  logic                       clk,
  input  logic                       n_reset,
  vector_csr_file_if.slave           bus,
  input  logic                       sat_flag,
  input  logic                       vstart_we,
  input  logic [$clog2(VLEN+1)-1:0]  vstart_wdata,
  input  logic                       vstart_clr,
  output logic [$clog2(VLEN+1)-1:0]  vl,
  output logic [2:0]                 vsew,
  output logic [2:0]                 vlmul,
  output logic                       vta,
  output logic                       vma,
  output logic                       vill,
  output logic [$clog2(VLEN+1)-1:0]  vstart,
  output logic [1:0]                 vxrm
);
  localparam int unsigned VL_W = $clog2(VLEN+1);

  cfg_state_e      state_q, state_d;
  logic            cfg_ready_q, cfg_ready_d;
  logic            cfg_rsp_valid_q, cfg_rsp_valid_d;
  logic [XLEN-1:0] cfg_rsp_vl_q, cfg_rsp_vl_d;
  logic [XLEN-1:0] avl_q, avl_d;
  logic [XLEN-1:0] req_vtype_q, req_vtype_d;
  logic            keep_q, keep_d;
  logic            set_max_q, set_max_d;
  logic [VL_W-1:0] vlmax_q, vlmax_d;
  logic            cfg_ill_q, cfg_ill_d;
  logic [VL_W-1:0] vl_q, vl_d;
  vtype_t          vtype_q, vtype_d;
  logic [VL_W-1:0] vstart_q, vstart_d;
  logic            vxsat_q, vxsat_d;
  logic [1:0]      vxrm_q, vxrm_d;
  logic            csr_rsp_valid_q, csr_rsp_valid_d;
  logic [XLEN-1:0] csr_rdata_q, csr_rdata_d;
  logic            csr_illegal_q, csr_illegal_d;

  logic [VL_W-1:0] vlmax_c;
  logic            illegal_c;
  logic            commit;
  csr_op_e         op;
  logic [XLEN-1:0] csr_old, csr_new;
  logic            csr_mapped, csr_ro, csr_writes, csr_ill, csr_do_write;

  vlmax_calc #(.VLEN(VLEN), .ELEN(ELEN), .XLEN(XLEN)) u_vlmax_calc (
    .vtype_i   (req_vtype_q),
    .vlmax_o   (vlmax_c),
    .illegal_o (illegal_c)
  );

  // Configuration FSM, CSR decode and next-state for every register
  always_comb begin
    state_d         = state_q;
    cfg_rsp_valid_d = 1'b0;
    cfg_rsp_vl_d    = cfg_rsp_vl_q;
    avl_d           = avl_q;
    req_vtype_d     = req_vtype_q;
    keep_d          = keep_q;
    set_max_d       = set_max_q;
    vlmax_d         = vlmax_q;
    cfg_ill_d       = cfg_ill_q;
    vl_d            = vl_q;
    vtype_d         = vtype_q;
    vstart_d        = vstart_q;
    vxsat_d         = vxsat_q;
    vxrm_d          = vxrm_q;
    commit          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid && cfg_ready_q) begin
          avl_d       = bus.cfg_avl;
          req_vtype_d = bus.cfg_vtype;
          keep_d      = bus.cfg_keep_vl;
          set_max_d   = bus.cfg_set_max;
          state_d     = ST_CALC;
        end
      end
      ST_CALC: begin
        vlmax_d   = vlmax_c;
        cfg_ill_d = illegal_c;
        state_d   = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit          = 1'b1;
        cfg_rsp_valid_d = 1'b1;
        state_d         = ST_IDLE;
        if (cfg_ill_q) begin
          vtype_d = VTYPE_RESET;
          vl_d    = '0;
        end else begin
          vtype_d = '{vill: 1'b0, reserved: '0,
                      vma: req_vtype_q[7], vta: req_vtype_q[6],
                      vsew: req_vtype_q[5:3], vlmul: req_vtype_q[2:0]};
          if (set_max_q)                     vl_d = vlmax_q;
          else if (keep_q)                   vl_d = vl_q;
          else if (avl_q < XLEN'(vlmax_q))   vl_d = VL_W'(avl_q);
          else                               vl_d = vlmax_q;
        end
        cfg_rsp_vl_d = XLEN'(vl_d);
      end
      default: state_d = ST_IDLE;
    endcase
    cfg_ready_d = (state_d == ST_IDLE);

    // CSR decode: old value, mapping and access legality
    op         = csr_op_e'(bus.csr_op);
    csr_old    = '0;
    csr_mapped = 1'b1;
    csr_ro     = 1'b0;
    case (bus.csr_addr)
      CSR_VSTART: csr_old = XLEN'(vstart_q);
      CSR_VXSAT:  csr_old = XLEN'(vxsat_q);
      CSR_VXRM:   csr_old = XLEN'(vxrm_q);
      CSR_VCSR:   csr_old = XLEN'({vxrm_q, vxsat_q});
      CSR_VL:     begin csr_old = XLEN'(vl_q); csr_ro = 1'b1; end
      CSR_VTYPE:  begin
        csr_old = {vtype_q.vill, (XLEN-1)'(vtype_q[VTYPE_W-2:0])};
        csr_ro  = 1'b1;
      end
      CSR_VLENB:  begin csr_old = XLEN'(VLEN / 8); csr_ro = 1'b1; end
      default:    csr_mapped = 1'b0;
    endcase
    // set/clear with a zero mask is a pure read
    csr_writes = (op == CSR_WRITE) ||
                 ((op == CSR_SET || op == CSR_CLEAR) && (bus.csr_wdata != '0));
    csr_ill      = !csr_mapped || (csr_ro && csr_writes);
    csr_do_write = bus.csr_valid && csr_writes && !csr_ill;
    unique case (op)
      CSR_WRITE: csr_new = bus.csr_wdata;
      CSR_SET:   csr_new = csr_old | bus.csr_wdata;
      CSR_CLEAR: csr_new = csr_old & ~bus.csr_wdata;
      default:   csr_new = csr_old;
    endcase

    if (csr_do_write) begin
      case (bus.csr_addr)
        CSR_VXSAT: vxsat_d = 1'(csr_new);
        CSR_VXRM:  vxrm_d  = 2'(csr_new);
        CSR_VCSR:  begin
          vxsat_d = 1'(csr_new);
          vxrm_d  = 2'(csr_new >> 1);
        end
        default: ;
      endcase
    end
    if (sat_flag) vxsat_d = 1'b1;

    // vstart: later assignments win (commit > CSR write > vstart_we > vstart_clr)
    if (vstart_clr) vstart_d = '0;
    if (vstart_we)  vstart_d = vstart_wdata;
    if (csr_do_write && bus.csr_addr == CSR_VSTART) vstart_d = VL_W'(csr_new);
    if (commit)     vstart_d = '0;

    csr_rsp_valid_d = bus.csr_valid;
    csr_rdata_d     = bus.csr_valid ? csr_old : '0;
    csr_illegal_d   = bus.csr_valid && csr_ill;
  end

  // State registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q         <= ST_IDLE;
      cfg_ready_q     <= 1'b1;
      cfg_rsp_valid_q <= 1'b0;
      cfg_rsp_vl_q    <= '0;
      avl_q           <= '0;
      req_vtype_q     <= '0;
      keep_q          <= 1'b0;
      set_max_q       <= 1'b0;
      vlmax_q         <= '0;
      cfg_ill_q       <= 1'b0;
      vl_q            <= '0;
      vtype_q         <= VTYPE_RESET;
      vstart_q        <= '0;
      vxsat_q         <= 1'b0;
      vxrm_q          <= '0;
      csr_rsp_valid_q <= 1'b0;
      csr_rdata_q     <= '0;
      csr_illegal_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cfg_ready_q     <= cfg_ready_d;
      cfg_rsp_valid_q <= cfg_rsp_valid_d;
      cfg_rsp_vl_q    <= cfg_rsp_vl_d;
      avl_q           <= avl_d;
      req_vtype_q     <= req_vtype_d;
      keep_q          <= keep_d;
      set_max_q       <= set_max_d;
      vlmax_q         <= vlmax_d;
      cfg_ill_q       <= cfg_ill_d;
      vl_q            <= vl_d;
      vtype_q         <= vtype_d;
      vstart_q        <= vstart_d;
      vxsat_q         <= vxsat_d;
      vxrm_q          <= vxrm_d;
      csr_rsp_valid_q <= csr_rsp_valid_d;
      csr_rdata_q     <= csr_rdata_d;
      csr_illegal_q   <= csr_illegal_d;
    end
  end

  assign bus.cfg_ready     = cfg_ready_q;
  assign bus.cfg_rsp_valid = cfg_rsp_valid_q;
  assign bus.cfg_rsp_vl    = cfg_rsp_vl_q;
  assign bus.csr_rsp_valid = csr_rsp_valid_q;
  assign bus.csr_rdata     = csr_rdata_q;
  assign bus.csr_illegal   = csr_illegal_q;

  assign vl     = vl_q;
  assign vsew   = vtype_q.vsew;
  assign vlmul  = vtype_q.vlmul;
  assign vta    = vtype_q.vta;
  assign vma    = vtype_q.vma;
  assign vill   = vtype_q.vill;
  assign vstart = vstart_q;
  assign vxrm   = vxrm_q;

endmodule

// File: tb/tb_vector_csr_file.sv
// Self-checking bench for vector_csr_file: reference model plus scoreboard
// queues for CSR and vsetvl responses, checked at the falling clock edge.
module tb_vector_csr_file;
  localparam int unsigned VLEN = 128;
  localparam int unsigned ELEN = 32;
  localparam int unsigned XLEN = 32;
  localparam int unsigned VL_W = $clog2(VLEN+1);

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  vector_csr_file_if #(.XLEN(XLEN)) bus();

  logic            sat_flag, vstart_we, vstart_clr;
  logic [VL_W-1:0] vstart_wdata, vl, vstart;
  logic [2:0]      vsew, vlmul;
  logic            vta, vma, vill;
  logic [1:0]      vxrm;

  vector_csr_file #(.VLEN(VLEN), .ELEN(ELEN), .XLEN(XLEN)) dut (
    .clk(clk), .n_reset(n_reset), .bus(bus),
    .sat_flag(sat_flag), .vstart_we(vstart_we), .vstart_wdata(vstart_wdata),
    .vstart_clr(vstart_clr), .vl(vl), .vsew(vsew), .vlmul(vlmul),
    .vta(vta), .vma(vma), .vill(vill), .vstart(vstart), .vxrm(vxrm)
  );

  typedef struct { logic [31:0] rdata; logic ill; } csr_exp_t;
  csr_exp_t    csr_q[$];
  logic [31:0] cfg_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [31:0] m_vl, m_vstart;
  logic        m_vill, m_vxsat;
  logic [7:0]  m_vt;
  logic [1:0]  m_vxrm;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vl = 0; m_vstart = 0; m_vill = 1'b1; m_vxsat = 1'b0; m_vt = 8'h00; m_vxrm = 2'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a, output bit mapped, output bit ro);
    mapped = 1'b1; ro = 1'b0;
    case (a)
      12'h008: return m_vstart;
      12'h009: return {31'd0, m_vxsat};
      12'h00A: return {30'd0, m_vxrm};
      12'h00F: return {29'd0, m_vxrm, m_vxsat};
      12'hC20: begin ro = 1'b1; return m_vl; end
      12'hC21: begin ro = 1'b1; return {m_vill, 23'd0, m_vt}; end
      12'hC22: begin ro = 1'b1; return 32'(VLEN / 8); end
      default: begin mapped = 1'b0; return 32'd0; end
    endcase
  endfunction

  task automatic check_lanes(input string tag);
    check_val({tag, "_vl"},     32'(vl),     m_vl);
    check_val({tag, "_vill"},   32'(vill),   32'(m_vill));
    check_val({tag, "_vsew"},   32'(vsew),   32'(m_vt[5:3]));
    check_val({tag, "_vlmul"},  32'(vlmul),  32'(m_vt[2:0]));
    check_val({tag, "_vta"},    32'(vta),    32'(m_vt[6]));
    check_val({tag, "_vma"},    32'(vma),    32'(m_vt[7]));
    check_val({tag, "_vstart"}, 32'(vstart), m_vstart);
    check_val({tag, "_vxrm"},   32'(vxrm),   32'(m_vxrm));
  endtask

  // One CSR access; optional same-cycle sat_flag
  task automatic csr_xfer(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd, input bit sat);
    logic [31:0] old, nv;
    bit mapped, ro, wr, ill;
    csr_exp_t e;
    @(negedge clk);
    old = model_read(a, mapped, ro);
    wr  = (op == 2'd1) || (op != 2'd0 && wd != 32'd0);
    ill = !mapped || (ro && wr);
    e.rdata = old; e.ill = ill;
    csr_q.push_back(e);
    bus.csr_valid = 1'b1; bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = wd; sat_flag = sat;
    if (!ill && wr) begin
      nv = (op == 2'd1) ? wd : (op == 2'd2) ? (old | wd) : (old & ~wd);
      case (a)
        12'h008: m_vstart = nv & 32'((1 << VL_W) - 1);
        12'h009: m_vxsat  = nv[0];
        12'h00A: m_vxrm   = nv[1:0];
        12'h00F: begin m_vxrm = nv[2:1]; m_vxsat = nv[0]; end
        default: ;
      endcase
    end
    if (sat) m_vxsat = 1'b1;
    @(negedge clk);
    bus.csr_valid = 1'b0; sat_flag = 1'b0;
  endtask

  // One vsetvl request through the full accept/calc/commit sequence
  task automatic do_cfg(input logic [31:0] avl, input logic [31:0] vt, input bit keep, input bit setmax);
    int unsigned sew, lm, vlmax;
    bit ill;
    logic [31:0] nvl;
    @(negedge clk);
    check_val("cfg_ready_idle", 32'(bus.cfg_ready), 32'd1);
    sew = 32'd8 << vt[5:3];
    lm  = 32'(vt[2:0]);
    ill = (vt[5:3] > 3'd2) || (sew > ELEN) || (lm == 4) || (vt[31:8] != 24'd0);
    if (lm < 4) vlmax = (VLEN / sew) << lm;
    else begin
`ifdef VCSR_FRACTIONAL_LMUL_EN
      vlmax = (VLEN / sew) / (32'd1 << (8 - lm));
      if (sew * (32'd1 << (8 - lm)) > ELEN) ill = 1'b1;
`else
      vlmax = 0;
      ill   = 1'b1;
`endif
    end
    if (ill) begin
      nvl = 0; m_vill = 1'b1; m_vt = 8'h00;
    end else begin
      m_vill = 1'b0; m_vt = vt[7:0];
      if (setmax)           nvl = vlmax;
      else if (keep)        nvl = m_vl;
      else if (avl < vlmax) nvl = avl;
      else                  nvl = vlmax;
    end
    cfg_q.push_back(nvl);
    bus.cfg_valid = 1'b1; bus.cfg_avl = avl; bus.cfg_vtype = vt;
    bus.cfg_keep_vl = keep; bus.cfg_set_max = setmax;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    check_val("cfg_ready_calc", 32'(bus.cfg_ready), 32'd0);
    @(negedge clk);
    check_val("cfg_ready_commit", 32'(bus.cfg_ready), 32'd0);
    m_vl = nvl; m_vstart = 0;
    @(negedge clk);
    check_val("cfg_ready_back", 32'(bus.cfg_ready), 32'd1);
    check_lanes("cfg");
  endtask

  // Response monitor: pop scoreboard entries as responses appear
  always @(negedge clk) begin
    csr_exp_t e;
    logic [31:0] ev;
    if (n_reset === 1'b1) begin
      if (bus.csr_rsp_valid) begin
        if (csr_q.size() == 0) check_val("csr_rsp_spurious", 32'(bus.csr_rsp_valid), 32'd0);
        else begin
          e = csr_q.pop_front();
          check_val("csr_rdata", bus.csr_rdata, e.rdata);
          check_val("csr_illegal", 32'(bus.csr_illegal), 32'(e.ill));
        end
      end
      if (bus.cfg_rsp_valid) begin
        if (cfg_q.size() == 0) check_val("cfg_rsp_spurious", 32'(bus.cfg_rsp_valid), 32'd0);
        else begin
          ev = cfg_q.pop_front();
          check_val("cfg_rsp_vl", bus.cfg_rsp_vl, ev);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_reset = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_avl = '0; bus.cfg_vtype = '0;
    bus.cfg_keep_vl = 1'b0; bus.cfg_set_max = 1'b0;
    bus.csr_valid = 1'b0; bus.csr_addr = '0; bus.csr_op = '0; bus.csr_wdata = '0;
    sat_flag = 1'b0; vstart_we = 1'b0; vstart_wdata = '0; vstart_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);

    // reset state
    check_lanes("reset");
    check_val("reset_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check_val("reset_cfg_rsp", 32'(bus.cfg_rsp_valid), 32'd0);
    check_val("reset_csr_rsp", 32'(bus.csr_rsp_valid), 32'd0);
    check_val("reset_csr_ill", 32'(bus.csr_illegal), 32'd0);
    csr_xfer(2'd0, 12'hC21, 32'd0, 1'b0);
    csr_xfer(2'd0, 12'hC22, 32'd0, 1'b0);

    // vsetvl configurations
    do_cfg(32'd100, 32'h012, 1'b0, 1'b0);
    check_val("vl_sew32_lmul4", 32'(vl), 32'd16);
    do_cfg(32'd17, 32'h001, 1'b0, 1'b0);
    check_val("vl_avl17", 32'(vl), 32'd17);
    do_cfg(32'd3, 32'h010, 1'b1, 1'b0);
    check_val("vl_keep", 32'(vl), 32'd17);
    check_val("vsew_keep", 32'(vsew), 32'd2);
    do_cfg(32'd5, 32'h018, 1'b0, 1'b0);
    check_val("vill_sew64", 32'(vill), 32'd1);
    csr_xfer(2'd0, 12'hC21, 32'd0, 1'b0);
    do_cfg(32'd5, 32'h005, 1'b0, 1'b0);
    do_cfg(32'd1, 32'h0C0, 1'b0, 1'b1);
    do_cfg(32'hFFFF_FFFF, 32'h000, 1'b0, 1'b0);
    check_val("vl_huge_avl", 32'(vl), 32'd16);
    do_cfg(32'd4, 32'h1_0000, 1'b0, 1'b0);
    do_cfg(32'd4, 32'h004, 1'b0, 1'b0);
    do_cfg(32'd9, 32'h00A, 1'b0, 1'b0);

    // CSR map, RO protection and set/clear semantics
    csr_xfer(2'd1, 12'hC20, 32'd7, 1'b0);
    csr_xfer(2'd0, 12'hC20, 32'd0, 1'b0);
    csr_xfer(2'd2, 12'hC20, 32'd0, 1'b0);
    csr_xfer(2'd3, 12'hC21, 32'd0, 1'b0);
    csr_xfer(2'd3, 12'hC22, 32'd1, 1'b0);
    csr_xfer(2'd1, 12'h123, 32'd1, 1'b0);
    csr_xfer(2'd0, 12'h123, 32'd0, 1'b0);
    csr_xfer(2'd1, 12'h00F, 32'd5, 1'b0);
    check_val("vxrm_from_vcsr", 32'(vxrm), 32'd2);
    csr_xfer(2'd0, 12'h009, 32'd0, 1'b0);
    csr_xfer(2'd2, 12'h00A, 32'd1, 1'b0);
    csr_xfer(2'd3, 12'h00F, 32'd7, 1'b0);
    csr_xfer(2'd0, 12'h00F, 32'd0, 1'b0);

    // sat_flag wins over a same-cycle clear of vxsat
    csr_xfer(2'd3, 12'h009, 32'd1, 1'b1);
    csr_xfer(2'd0, 12'h009, 32'd0, 1'b0);

    // vstart sources and priorities
    vstart_we = 1'b1; vstart_wdata = 8'd5;
    @(negedge clk);
    vstart_we = 1'b0; m_vstart = 32'd5;
    check_val("vstart_we", 32'(vstart), 32'd5);
    csr_xfer(2'd0, 12'h008, 32'd0, 1'b0);
    vstart_we = 1'b1; vstart_wdata = 8'd3; m_vstart = 32'd3;
    csr_xfer(2'd1, 12'h008, 32'd7, 1'b0);
    vstart_we = 1'b0;
    check_val("vstart_csr_beats_we", 32'(vstart), 32'd7);
    vstart_we = 1'b1; vstart_wdata = 8'd9; vstart_clr = 1'b1;
    @(negedge clk);
    vstart_we = 1'b0; m_vstart = 32'd9;
    check_val("vstart_we_beats_clr", 32'(vstart), 32'd9);
    @(negedge clk);
    vstart_clr = 1'b0; m_vstart = 32'd0;
    check_val("vstart_clr", 32'(vstart), 32'd0);
    vstart_we = 1'b1; vstart_wdata = 8'd5;
    @(negedge clk);
    vstart_we = 1'b0; m_vstart = 32'd5;
    do_cfg(32'd8, 32'h000, 1'b0, 1'b0);
    check_val("vstart_commit_zero", 32'(vstart), 32'd0);

    // reset during CALC: no commit, everything back to reset values
    @(negedge clk);
    bus.cfg_valid = 1'b1; bus.cfg_avl = 32'd3; bus.cfg_vtype = 32'h011;
    bus.cfg_keep_vl = 1'b0; bus.cfg_set_max = 1'b0;
    @(negedge clk);
    bus.cfg_valid = 1'b0; n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1; model_reset();
    repeat (3) @(negedge clk);
    check_lanes("midreset");
    check_val("midreset_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    csr_xfer(2'd0, 12'hC21, 32'd0, 1'b0);

    repeat (3) @(negedge clk);
    check_val("csr_queue_drained", 32'(csr_q.size()), 32'd0);
    check_val("cfg_queue_drained", 32'(cfg_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
